message_writeback_serializer: RTL and testbench

- Receiving end of the sequential message passer's output interface: captures each `valid` cycle's full-width horizontal_out/vertical_out vectors.
- Buffers captured vectors in a small FIFO and serializes them into narrow beats for the message-memory write port.
- The message memory applies backpressure (valid/ready); the passer cannot stall, so the block flags dropped results.

---
 rtl/message_writeback_serializer.sv | 175 +++++++++++++++++
 tb/tb_message_writeback_serializer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/message_writeback_serializer.sv
// -----------------------------------------------------------------------------
// message_writeback_serializer
//
// Receiving end of the sequential message passer. Every `valid` cycle the full
// horizontal/vertical message vectors are captured into a small FIFO. The head
// entry is then sent to the message memory as narrow beats: BEATS horizontal
// beats followed by BEATS vertical beats, under valid/ready flow control. The
// passer cannot be stalled, so a capture with no free slot is dropped and
// flagged on the sticky `overflow` output.
//
// Ports:
//   clk           clock, all state updates on posedge
//   rst           asynchronous, active-high reset
//   valid         passer result strobe, capture inputs this cycle
//   horizontal_in horizontal vector, label i at [(i+1)*MESSAGE_WIDTH-1 -: MESSAGE_WIDTH]
//   vertical_in   vertical vector, same packing
//   wr_valid      beat available
//   wr_ready      memory accepts the beat
//   wr_data       beat payload, label b*WORD_LABELS+k in slot k (slot 0 = LSBs)
//   wr_vertical   0 = horizontal beat, 1 = vertical beat
//   wr_beat       beat index within the current half
//   wr_last       final beat of the entry
//   wr_count      entries fully written (wraps at 2^16)
//   full          FIFO occupancy == DEPTH
//   overflow      sticky, a `valid` was dropped
// -----------------------------------------------------------------------------
module message_writeback_serializer #(
    parameter int LABELS        = 16,
    parameter int MESSAGE_WIDTH = 6,
    parameter int WORD_LABELS   = 4,
    parameter int DEPTH         = 4,
    localparam int BEATS        = LABELS / WORD_LABELS,
    localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid,
    input  logic [LABELS*MESSAGE_WIDTH-1:0]      horizontal_in,
    input  logic [LABELS*MESSAGE_WIDTH-1:0]      vertical_in,
    output logic                                wr_valid,
    input  logic                                wr_ready,
    output logic [WORD_LABELS*MESSAGE_WIDTH-1:0] wr_data,
    output logic                                wr_vertical,
    output logic [BEAT_W-1:0]                   wr_beat,
    output logic                                wr_last,
    output logic [15:0]                         wr_count,
    output logic                                full,
    output logic                                overflow
);

    localparam int VEC_W   = LABELS * MESSAGE_WIDTH;
    localparam int SLICE_W = WORD_LABELS * MESSAGE_WIDTH;
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W   = $clog2(DEPTH + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SEND_H = 2'd1;
    localparam logic [1:0] SEND_V = 2'd2;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(DEPTH);

    logic [VEC_W-1:0] h_mem [DEPTH];
    logic [VEC_W-1:0] v_mem [DEPTH];

    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W-1:0]  occupancy_next;
    logic [1:0]        state;
    logic [BEAT_W-1:0] beat;
    logic [VEC_W-1:0]  head;
    logic              handshake;
    logic              pop;
    logic              space;
    logic              push;

    // All beat outputs are decoded from registers only, so they cannot move
    // while the memory holds wr_ready low.
    assign wr_valid    = (state != IDLE);
    assign wr_vertical = (state == SEND_V);
    assign wr_beat     = beat;
    assign wr_last     = wr_vertical && (beat == LAST_BEAT);
    assign head        = wr_vertical ? v_mem[rd_ptr] : h_mem[rd_ptr];
    assign wr_data     = head[beat * SLICE_W +: SLICE_W];

    assign handshake = wr_valid && wr_ready;
    assign pop       = handshake && wr_last;
    // The last-beat handshake frees the head slot in the same cycle, so a full
    // FIFO can still accept a capture then.
    assign space     = (occupancy < DEPTH_OCC) || pop;
    assign push      = valid && space;

    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        occupancy_next = occupancy;
        case ({push, pop})
            2'b10:   occupancy_next = occupancy + 1'b1;
            2'b01:   occupancy_next = occupancy - 1'b1;
            default: occupancy_next = occupancy;
        endcase
    end

    // NOTE: storage is deliberately not reset; the pointers and occupancy
    // decide what is valid, and leaving the arrays out keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            h_mem[wr_ptr] <= horizontal_in;
            v_mem[wr_ptr] <= vertical_in;
        end
    end

    // NOTE: non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            wr_count  <= '0;
            state     <= IDLE;
            beat      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                wr_count <= wr_count + 16'd1;
            end
            if (valid && !space) begin
                overflow <= 1'b1;
            end
            occupancy <= occupancy_next;
            full      <= (occupancy_next == DEPTH_OCC);

            case (state)
                IDLE: begin
                    if (occupancy != '0) begin
                        state <= SEND_H;
                        beat  <= '0;
                    end
                end
                SEND_H: begin
                    if (handshake) begin
                        if (beat == LAST_BEAT) begin
                            state <= SEND_V;
                            beat  <= '0;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                SEND_V: begin
                    if (handshake) begin
                        if (beat == LAST_BEAT) begin
                            // Occupancy after this pop (including any same-cycle
                            // capture) decides whether to continue without a gap.
                            beat  <= '0;
                            state <= (occupancy_next != '0) ? SEND_H : IDLE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_message_writeback_serializer.sv
// -----------------------------------------------------------------------------
// tb_message_writeback_serializer
//
// Self-checking bench. Inputs are driven on the falling edge. A reference model
// keeps the FIFO contents as a queue of whole entries and the position of the
// head entry within its 2*BEATS-beat transfer. It predicts the cycle and
// payload of every accepted beat, along with wr_count, overflow and full.
// -----------------------------------------------------------------------------
module tb_message_writeback_serializer;

    localparam int LABELS        = 16;
    localparam int MESSAGE_WIDTH = 6;
    localparam int WORD_LABELS   = 4;
    localparam int DEPTH         = 4;
    localparam int BEATS         = LABELS / WORD_LABELS;
    localparam int VEC_W         = LABELS * MESSAGE_WIDTH;
    localparam int SLICE_W       = WORD_LABELS * MESSAGE_WIDTH;

    typedef struct packed {
        logic [VEC_W-1:0] h;
        logic [VEC_W-1:0] v;
    } entry_t;

    typedef struct packed {
        logic [31:0]        cyc;
        logic               vert;
        logic [1:0]         beat;
        logic               last;
        logic [SLICE_W-1:0] data;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               valid = 1'b0;
    logic [VEC_W-1:0]   horizontal_in = '0;
    logic [VEC_W-1:0]   vertical_in = '0;
    logic               wr_valid;
    logic               wr_ready = 1'b0;
    logic [SLICE_W-1:0] wr_data;
    logic               wr_vertical;
    logic [1:0]         wr_beat;
    logic               wr_last;
    logic [15:0]        wr_count;
    logic               full;
    logic               overflow;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    entry_t      m_q[$];
    int          m_pos = 0;
    bit          m_active = 0;
    logic [15:0] m_count = '0;
    logic        m_overflow = 1'b0;
    logic [31:0] cyc = '0;
    beat_t       obs_q[$];
    beat_t       exp_q[$];

    message_writeback_serializer #(
        .LABELS(LABELS), .MESSAGE_WIDTH(MESSAGE_WIDTH),
        .WORD_LABELS(WORD_LABELS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid),
        .horizontal_in(horizontal_in), .vertical_in(vertical_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .wr_vertical(wr_vertical), .wr_beat(wr_beat), .wr_last(wr_last),
        .wr_count(wr_count), .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Beat b of a half: labels b*WORD_LABELS .. b*WORD_LABELS+WORD_LABELS-1.
    function automatic logic [SLICE_W-1:0] expected_slice(input logic [VEC_W-1:0] vec, input int b);
        logic [SLICE_W-1:0] s;
        s = '0;
        for (int k = 0; k < WORD_LABELS; k++)
            s[k*MESSAGE_WIDTH +: MESSAGE_WIDTH] = vec[(b*WORD_LABELS + k)*MESSAGE_WIDTH +: MESSAGE_WIDTH];
        return s;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_clear();
        m_q.delete();
        obs_q.delete();
        exp_q.delete();
        m_pos      = 0;
        m_active   = 0;
        m_count    = '0;
        m_overflow = 1'b0;
    endtask

    // Drive one cycle (called at a falling edge), record the DUT handshake, and
    // advance the model by the same clock edge.
    task automatic step(input logic v_in, input logic rdy,
                        input logic [VEC_W-1:0] h_vec, input logic [VEC_W-1:0] v_vec);
        bit     hs;
        bit     pop_now;
        bit     had_entries;
        entry_t e;
        valid         = v_in;
        wr_ready      = rdy;
        horizontal_in = h_vec;
        vertical_in   = v_vec;
        #1;
        if (wr_valid && wr_ready)
            obs_q.push_back('{cyc, wr_vertical, wr_beat, wr_last, wr_data});
        hs          = m_active && rdy;
        pop_now     = hs && (m_pos == 2*BEATS - 1);
        had_entries = m_q.size() > 0;
        if (hs) begin
            e = m_q[0];
            exp_q.push_back('{cyc, (m_pos >= BEATS), 2'(m_pos % BEATS), pop_now,
                              (m_pos < BEATS) ? expected_slice(e.h, m_pos)
                                              : expected_slice(e.v, m_pos - BEATS)});
        end
        if (v_in) begin
            if (m_q.size() < DEPTH || pop_now) m_q.push_back('{h_vec, v_vec});
            else m_overflow = 1'b1;
        end
        if (hs) begin
            if (pop_now) begin
                void'(m_q.pop_front());
                m_pos    = 0;
                m_count  = m_count + 16'd1;
                m_active = m_q.size() > 0;
            end else begin
                m_pos++;
            end
        end else if (!m_active) begin
            m_active = had_entries;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        valid    = 1'b0;
        wr_ready = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        horizontal_in = rand_vec();
        vertical_in   = rand_vec();
        valid         = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL reset_wr_valid: got %b want 0", wr_valid); else n_pass++;
        n_checks++; if (wr_count !== 16'd0) $display("FAIL reset_wr_count: got %0d want 0", wr_count); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
        apply_reset();
    endtask

    task automatic test_single();
        logic [VEC_W-1:0] h;
        logic [VEC_W-1:0] v;
        int n_last;
        for (int i = 0; i < LABELS; i++) begin
            h[i*MESSAGE_WIDTH +: MESSAGE_WIDTH] = MESSAGE_WIDTH'(1 + i);
            v[i*MESSAGE_WIDTH +: MESSAGE_WIDTH] = MESSAGE_WIDTH'(1 + 2*i);
        end
        apply_reset();
        step(1'b1, 1'b1, h, v);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, '0, '0);
        n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL single_beats: got %0d beats want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL single_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        if (obs_q.size() == 8) begin
            n_checks++; if (obs_q[0].data !== 24'h103081) $display("FAIL single_h0_data: got %h want 103081", obs_q[0].data); else n_pass++;
            n_checks++; if (obs_q[4].data !== 24'h1C50C1) $display("FAIL single_v0_data: got %h want 1c50c1", obs_q[4].data); else n_pass++;
        end
        n_last = 0;
        foreach (obs_q[i]) if (obs_q[i].last) n_last++;
        n_checks++; if (n_last !== 1) $display("FAIL single_last_count: got %0d want 1", n_last); else n_pass++;
        n_checks++; if (wr_count !== 16'd1) $display("FAIL single_wr_count: got %0d want 1", wr_count); else n_pass++;
        n_checks++; if (overflow !== 1'b0) $display("FAIL single_overflow: got %b want 0", overflow); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [VEC_W-1:0] h;
        logic [VEC_W-1:0] v;
        logic [31:0]      c0;
        for (int i = 0; i < LABELS; i++) begin
            h[i*MESSAGE_WIDTH +: MESSAGE_WIDTH] = MESSAGE_WIDTH'(1 + i);
            v[i*MESSAGE_WIDTH +: MESSAGE_WIDTH] = MESSAGE_WIDTH'(1 + 2*i);
        end
        apply_reset();
        c0 = cyc;
        step(1'b1, 1'b1, h, v);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0, '0);
        // H beat 2 is now presented; hold wr_ready low for three cycles.
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({wr_valid, wr_vertical, wr_beat, wr_data} !== {1'b1, 1'b0, 2'd2, expected_slice(h, 2)})
                $display("FAIL bp_hold[%0d]: got v=%b vert=%b beat=%0d data=%h want v=1 vert=0 beat=2 data=%h",
                         i, wr_valid, wr_vertical, wr_beat, wr_data, expected_slice(h, 2));
            else n_pass++;
            step(1'b0, (i == 3), '0, '0);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, '0);
        n_checks++; if (obs_q.size() !== 8) $display("FAIL bp_beats: got %0d want 8", obs_q.size()); else n_pass++;
        if (obs_q.size() == 8) begin
            n_checks++; if (obs_q[7].cyc - c0 !== 32'd12) $display("FAIL bp_completion: got %0d cycles want 12", obs_q[7].cyc - c0); else n_pass++;
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL bp_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_fill_overflow();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, rand_vec(), rand_vec());
            if (i == 2) begin
                n_checks++; if (full !== 1'b0) $display("FAIL fill_full_3: got %b want 0", full); else n_pass++;
            end
            if (i == 3) begin
                n_checks++; if (full !== 1'b1) $display("FAIL fill_full_4: got %b want 1", full); else n_pass++;
                n_checks++; if (overflow !== 1'b0) $display("FAIL fill_overflow_4: got %b want 0", overflow); else n_pass++;
            end
        end
        n_checks++; if (overflow !== 1'b1) $display("FAIL fill_overflow_5: got %b want 1", overflow); else n_pass++;
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, '0, '0);
        n_checks++; if (obs_q.size() !== 32) $display("FAIL fill_beats: got %0d want 32", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL fill_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (wr_count !== 16'd4) $display("FAIL fill_wr_count: got %0d want 4", wr_count); else n_pass++;
        n_checks++; if (overflow !== 1'b1) $display("FAIL fill_overflow_sticky: got %b want 1", overflow); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL fill_full_drained: got %b want 0", full); else n_pass++;
    endtask

    task automatic test_simultaneous_pop_push();
        int guard;
        apply_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, rand_vec(), rand_vec());
        guard = 0;
        while (!(wr_valid && wr_last) && guard < 20) begin
            step(1'b0, 1'b1, '0, '0);
            guard++;
        end
        n_checks++; if (guard >= 20) $display("FAIL simul_reach_last: timed out waiting for wr_last"); else n_pass++;
        step(1'b1, 1'b1, rand_vec(), rand_vec());
        n_checks++; if (overflow !== 1'b0) $display("FAIL simul_overflow: got %b want 0", overflow); else n_pass++;
        n_checks++; if (full !== 1'b1) $display("FAIL simul_full: got %b want 1", full); else n_pass++;
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1, '0, '0);
        n_checks++; if (obs_q.size() !== 40) $display("FAIL simul_beats: got %0d want 40", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL simul_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (wr_count !== 16'd5) $display("FAIL simul_wr_count: got %0d want 5", wr_count); else n_pass++;
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 7), rand_vec(), rand_vec());
        for (int i = 0; i < 60; i++) step(1'b0, 1'b1, '0, '0);
        n_checks++; if (obs_q.size() !== exp_q.size()) $display("FAIL rand_beats: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (wr_count !== m_count) $display("FAIL rand_wr_count: got %0d want %0d", wr_count, m_count); else n_pass++;
        n_checks++; if (overflow !== m_overflow) $display("FAIL rand_overflow: got %b want %b", overflow, m_overflow); else n_pass++;
        n_checks++; if (full !== (m_q.size() == DEPTH)) $display("FAIL rand_full: got %b want %b", full, (m_q.size() == DEPTH)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int guard;
        apply_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_vec(), rand_vec());
        guard = 0;
        while (!(wr_valid && wr_vertical && wr_beat == 2'd1 && wr_count == 16'd1) && guard < 40) begin
            step(1'b0, 1'b1, '0, '0);
            guard++;
        end
        n_checks++; if (guard >= 40) $display("FAIL rstmid_reach: timed out waiting for entry 2 V beat 1"); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++; if (wr_valid !== 1'b0) $display("FAIL rstmid_async_valid: got %b want 0", wr_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, '0, '0);
        n_checks++; if (obs_q.size() !== 0) $display("FAIL rstmid_no_beats: got %0d want 0", obs_q.size()); else n_pass++;
        n_checks++; if (wr_count !== 16'd0) $display("FAIL rstmid_wr_count: got %0d want 0", wr_count); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL rstmid_full: got %b want 0", full); else n_pass++;
        step(1'b1, 1'b1, rand_vec(), rand_vec());
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, '0, '0);
        n_checks++; if (obs_q.size() !== 8) $display("FAIL rstmid_new_beats: got %0d want 8", obs_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rstmid_beat[%0d]: got %h want %h", i, obs_q[i], exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_fill_overflow();
        test_simultaneous_pop_push();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
